// File: rtl/oscilo_cmd_pkg.sv
// Shared types and constants for the UART command link of the oscilloscope.
// Imported by the RX-side framing logic and its timeout counter.
package oscilo_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARG,
      ST_DISPATCH,
      ST_RELEASE
   } rx_state_t;

   localparam logic [7:0] OP_GET_OFFSET  = 8'h01;
   localparam logic [7:0] OP_GET_SAMPLES = 8'h02;
   localparam logic [7:0] OP_SET_OFFSET  = 8'h81;
   localparam logic [7:0] OP_SET_TRIGGER = 8'h82;

   localparam int ARG_BYTES              = 4;
   localparam int TIMER_W                = 23;
   localparam int DEFAULT_TIMEOUT_CYCLES = 5_000_000;

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte idle counter for RX-side framers. expired is high in the cycle
// whose increment would bring the count to LIMIT, so the owner acts on that edge.
module rx_timeout
   import oscilo_cmd_pkg::*;
#(
   parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk_50mhz,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(LIMIT - 1);

   logic [TIMER_W-1:0] count;

   assign expired = enable && (count == LAST_COUNT);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk_50mhz) begin
      if (!reset || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cmd_receiver.sv
// Frames UART RX bytes into opcode + optional 32-bit big-endian argument and
// offers each complete command to the decoder over a four-phase handshake.
module cmd_receiver
   import oscilo_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int ARG_OPCODE_BIT = 7
) (
   input  logic        clk_50mhz,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  cmd_opcode,
   output logic [31:0] cmd_arg,
   output logic        cmd_activate,
   input  logic        cmd_done,
   output logic        err_timeout,
   output logic        err_overrun
);

   localparam logic [1:0] LAST_ARG_IDX = 2'(ARG_BYTES - 1);

   rx_state_t  state;
   logic [1:0] arg_idx;
   logic       timer_clear;
   logic       timer_expired;

   // An accepted byte restarts the gap; only an open argument frame can time out.
   assign timer_clear = rx_valid || (state != ST_ARG);

   rx_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_rx_timeout (
      .clk_50mhz (clk_50mhz),
      .reset     (reset),
      .clear     (timer_clear),
      .enable    (state == ST_ARG),
      .expired   (timer_expired)
   );

   always_ff @(posedge clk_50mhz) begin
      if (!reset) begin
         state        <= ST_IDLE;
         arg_idx      <= '0;
         cmd_opcode   <= '0;
         cmd_arg      <= '0;
         cmd_activate <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  cmd_opcode <= rx_data;
                  cmd_arg    <= '0;
                  if (rx_data[ARG_OPCODE_BIT]) begin
                     arg_idx <= '0;
                     state   <= ST_ARG;
                  end else begin
                     cmd_activate <= 1'b1;
                     state        <= ST_DISPATCH;
                  end
               end
            end
            ST_ARG: begin
               // A byte landing on the expiry cycle wins over the timeout.
               if (rx_valid) begin
                  cmd_arg <= {cmd_arg[23:0], rx_data};
                  if (arg_idx == LAST_ARG_IDX) begin
                     cmd_activate <= 1'b1;
                     state        <= ST_DISPATCH;
                  end else begin
                     arg_idx <= arg_idx + 1'b1;
                  end
               end else if (timer_expired) begin
                  cmd_arg     <= '0;
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_DISPATCH: begin
               if (rx_valid) begin
                  err_overrun <= 1'b1;
               end
               if (cmd_done) begin
                  cmd_activate <= 1'b0;
                  state        <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (rx_valid) begin
                  err_overrun <= 1'b1;
               end
               if (!cmd_done) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               cmd_activate <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cmd_receiver.md
# cmd_receiver

Host-to-device half of the UART control link. Consumes bytes from the UART receiver, frames them as an opcode optionally followed by a 32-bit big-endian argument, and dispatches each complete command to the sampler modules over an activate/done four-phase handshake. Sits between the UART RX core and the command decoder. It mirrors the device-to-host word senders, which serialise 32-bit values MSB-first over the TX side.

## Interface
- TIMEOUT_CYCLES, 5_000_000: maximum idle gap between bytes within one frame (100 ms at 50 MHz); must fit in 23 bits.
- ARG_OPCODE_BIT, 7: opcode bit that marks a command as carrying a 4-byte argument.
- clk_50mhz  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- cmd_opcode  output  8  opcode of the dispatched command.
- cmd_arg  output  32  argument of the dispatched command; 0 for no-argument opcodes.
- cmd_activate  output  1  held high while a command is offered to the decoder.
- cmd_done  input  1  decoder completion; four-phase with cmd_activate.
- err_timeout  output  1  one-cycle pulse when a partial frame is discarded.
- err_overrun  output  1  one-cycle pulse when a byte is dropped during dispatch.

## Operation
- States: ST_IDLE, ST_ARG (2-bit byte index 0..3), ST_DISPATCH, ST_RELEASE. Any undefined encoding returns to ST_IDLE.
- ST_IDLE, rx_valid: latch rx_data into cmd_opcode.
  - If rx_data[ARG_OPCODE_BIT]=1: clear cmd_arg, set index 0, go to ST_ARG.
  - Otherwise: set cmd_arg=0, go to ST_DISPATCH.
- ST_ARG, rx_valid: cmd_arg <= {cmd_arg[23:0], rx_data} (first byte ends up as MSB). On index 3, go to ST_DISPATCH; otherwise increment the index.
- ST_DISPATCH: cmd_activate=1. cmd_opcode and cmd_arg stay frozen. When cmd_done=1 is sampled, go to ST_RELEASE.
- ST_RELEASE: cmd_activate=0. Wait for cmd_done=0, then go to ST_IDLE.
- Timeout counter (23 bit):
  - Cleared on every accepted byte and in every state other than ST_ARG; increments in ST_ARG.
  - When it reaches TIMEOUT_CYCLES: return to ST_IDLE, pulse err_timeout, set cmd_arg=0.
  - cmd_opcode keeps its last value; it is ignored while cmd_activate=0.
- Overrun: rx_valid in ST_DISPATCH or ST_RELEASE drops the byte and pulses err_overrun. The state is unchanged.
- Reset (reset=0):
  - state=ST_IDLE; counter, index, cmd_opcode and cmd_arg all 0.
  - cmd_activate=0, err_timeout=0, err_overrun=0.
  - Reset mid-frame or mid-dispatch abandons the frame silently, with no error pulse.

## Timing
- All outputs are registered.
- Latency from the accepting rx_valid edge to cmd_activate=1 is one cycle, for both the no-arg opcode byte and the 4th argument byte.
- cmd_activate falls one cycle after cmd_done=1 is sampled.
- A new frame is accepted no earlier than the cycle after cmd_done=0 is sampled in ST_RELEASE.
- rx_valid in the same cycle the counter hits TIMEOUT_CYCLES: the byte wins. It is accepted, the counter clears, and no err_timeout is raised.
- rx_valid in the same cycle ST_RELEASE exits: the byte is dropped with err_overrun, because the state is evaluated before the transition.
- cmd_done high while in ST_IDLE or ST_ARG is ignored.
- err pulses are exactly one cycle wide. An overrun and a timeout cannot occur in the same cycle.
- Minimum byte spacing is 1 cycle; back-to-back rx_valid must be accepted.

## Structure
- Shared package oscilo_cmd_pkg:
  - state enum;
  - opcode constants OP_GET_OFFSET=8'h01, OP_GET_SAMPLES=8'h02, OP_SET_OFFSET=8'h81, OP_SET_TRIGGER=8'h82;
  - ARG_BYTES=4;
  - default TIMEOUT_CYCLES.
- One sub-module, rx_timeout: the 23-bit counter with clear/enable inputs and an expired output, reusable by other RX-side blocks.

## Test plan
- No-arg opcode: byte 8'h01; cmd_done raised 3 cycles after activate, then dropped.
  - Required: cmd_activate=1 one cycle after the strobe, cmd_opcode=8'h01, cmd_arg=0.
  - Required: activate falls one cycle after done; the next byte is accepted after done falls.
- Arg opcode: bytes 81,12,34,56,78 back-to-back.
  - Required: cmd_opcode=8'h81 and cmd_arg=32'h12345678 with cmd_activate=1 one cycle after the last byte.
- Timeout: 81,AA then silence, with TIMEOUT_CYCLES=100 for the test.
  - Required: single err_timeout pulse 100 cycles after the AA byte, cmd_activate never high.
  - Required: a following 01 frame dispatches normally.
- Boundary: byte arrives exactly when the counter reaches TIMEOUT_CYCLES.
  - Required: byte accepted, no err_timeout, frame completes.
- Overrun: byte 8'h02 sent while cmd_activate=1.
  - Required: err_overrun pulses for 1 cycle; cmd_opcode/cmd_arg unchanged; byte not dispatched later.
- Reset: reset=0 after bytes 81,12.
  - Required: all outputs 0 next cycle, no error pulse.
  - Required: a subsequent 81,00,00,00,05 yields cmd_arg=32'h00000005.
